// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM encoding and the per-round helper functions.
package sha1_pkg;

    localparam logic [159:0] SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_FINAL  = 2'd2,
        ST_DONE   = 2'd3
    } sha1_state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f_sel(input int t, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        if (t < 20)      return (b & c) | (~b & d);
        else if (t < 40) return b ^ c ^ d;
        else if (t < 60) return (b & c) | (b & d) | (c & d);
        else             return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] k_sel(input int t);
        if (t < 20)      return K0;
        else if (t < 40) return K1;
        else if (t < 60) return K2;
        else             return K3;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: maps (a..e, W[t], t) to the next a..e.
module sha1_round
    import sha1_pkg::*;
#(
    parameter int LOOP_W = 7
) (
    input  logic [31:0]       a_i,
    input  logic [31:0]       b_i,
    input  logic [31:0]       c_i,
    input  logic [31:0]       d_i,
    input  logic [31:0]       e_i,
    input  logic [31:0]       w_i,
    input  logic [LOOP_W-1:0] t_i,
    output logic [31:0]       a_o,
    output logic [31:0]       b_o,
    output logic [31:0]       c_o,
    output logic [31:0]       d_o,
    output logic [31:0]       e_o
);

    always_comb begin
        a_o = rotl(a_i, 5) + f_sel(int'(t_i), b_i, c_i, d_i) + e_i + k_sel(int'(t_i)) + w_i;
        b_o = a_i;
        c_o = rotl(b_i, 30);
        d_o = c_i;
        e_o = d_i;
    end

endmodule

// File: rtl/sha1_core.sv
// SHA-1 compression engine: one round per clock, chaining value kept across blocks.
module sha1_core
    import sha1_pkg::*;
#(
    parameter logic [159:0] IV     = SHA1_IV,
    parameter int           LOOP_W = 7
) (
    input  logic              wb_clk_i,
    input  logic              reset,
    input  logic              start,
    input  logic              init,
    input  logic [511:0]      message,
    output logic              busy,
    output logic              done,
    output logic              panic,
    output logic [LOOP_W-1:0] loop_idx,
    output logic [159:0]      digest
);

    sha1_state_e       state_q, state_d;
    logic [LOOP_W-1:0] t_q, t_d;
    logic              done_q, done_d;
    logic              panic_q, panic_d;
    logic [31:0]       h_q [5];
    logic [31:0]       h_d [5];
    logic [31:0]       v_q [5];   // working variables a..e
    logic [31:0]       v_d [5];
    logic [31:0]       w_q [16];
    logic [31:0]       w_d [16];

    logic [3:0]        w_idx;
    logic [31:0]       w_mix;
    logic [31:0]       w_t;
    logic [31:0]       rnd_v [5];
    logic              start_ok;

    // The ring slot for t holds W[t-16]; slots t+13, t+8, t+2 hold W[t-3], W[t-8], W[t-14].
    assign w_idx = t_q[3:0];
    assign w_mix = w_q[w_idx + 4'd13] ^ w_q[w_idx + 4'd8] ^ w_q[w_idx + 4'd2] ^ w_q[w_idx];
    assign w_t   = (t_q < LOOP_W'(16)) ? w_q[w_idx] : rotl(w_mix, 1);

    sha1_round #(.LOOP_W(LOOP_W)) u_round (
        .a_i (v_q[0]),
        .b_i (v_q[1]),
        .c_i (v_q[2]),
        .d_i (v_q[3]),
        .e_i (v_q[4]),
        .w_i (w_t),
        .t_i (t_q),
        .a_o (rnd_v[0]),
        .b_o (rnd_v[1]),
        .c_o (rnd_v[2]),
        .d_o (rnd_v[3]),
        .e_o (rnd_v[4])
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = done_q;
        panic_d = panic_q;
        h_d     = h_q;
        v_d     = v_q;
        w_d     = w_q;

        // A start coinciding with init is taken against the freshly loaded IV.
        start_ok = start && (init || state_q == ST_IDLE || state_q == ST_DONE);

        if (init) begin
            for (int i = 0; i < 5; i++) h_d[i] = IV[(4 - i) * 32 +: 32];
            done_d  = 1'b0;
            panic_d = 1'b0;
            t_d     = '0;
            state_d = ST_IDLE;
        end else if (start && !start_ok) begin
            panic_d = 1'b1;
        end

        if (start_ok) begin
            for (int i = 0; i < 16; i++) w_d[i] = message[32 * i +: 32];
            for (int i = 0; i < 5; i++) v_d[i] = init ? IV[(4 - i) * 32 +: 32] : h_q[i];
            done_d  = 1'b0;
            t_d     = '0;
            state_d = ST_ROUNDS;
        end else if (!init) begin
            case (state_q)
                ST_ROUNDS: begin
                    w_d[w_idx] = w_t;
                    v_d        = rnd_v;
                    if (t_q == LOOP_W'(79)) begin
                        t_d     = LOOP_W'(80);
                        state_d = ST_FINAL;
                    end else begin
                        t_d = t_q + LOOP_W'(1);
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 5; i++) h_d[i] = h_q[i] + v_q[i];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            done_q  <= 1'b0;
            panic_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                h_q[i] <= IV[(4 - i) * 32 +: 32];
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
            panic_q <= panic_d;
            h_q     <= h_d;
            v_q     <= v_d;
            w_q     <= w_d;
        end
    end

    assign busy     = (state_q == ST_ROUNDS) || (state_q == ST_FINAL);
    assign done     = done_q;
    assign panic    = panic_q;
    assign loop_idx = t_q;

    // H0 sits in the low word so the bus front end reads it first.
    for (genvar gi = 0; gi < 5; gi++) begin : g_digest
        assign digest[32 * gi +: 32] = h_q[gi];
    end

endmodule

// File: tb/tb_sha1_core.sv
// Directed and randomized checks of sha1_core against known digests and a plain SHA-1 model.
module tb_sha1_core;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         init;
    logic [511:0] message;
    logic         busy;
    logic         done;
    logic         panic;
    logic [6:0]   loop_idx;
    logic [159:0] digest;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [159:0] IV_DIG  = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
    localparam logic [159:0] ABC_DIG = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36};
    localparam logic [159:0] EMP_DIG = {32'hafd80709, 32'h95601890, 32'h3255bfef, 32'h5e6b4b0d, 32'hda39a3ee};
    localparam logic [159:0] TWO_DIG = {32'he54670f1, 32'hf95129e5, 32'hbaae4aa1, 32'h1c3bd26e, 32'h84983e44};
    localparam logic [31:0]  B1_W [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071};

    sha1_core dut (
        .wb_clk_i (clk),
        .reset    (reset),
        .start    (start),
        .init     (init),
        .message  (message),
        .busy     (busy),
        .done     (done),
        .panic    (panic),
        .loop_idx (loop_idx),
        .digest   (digest)
    );

    always #5 clk = ~clk;

    // Reference model: textbook SHA-1 compression over an 80-entry schedule.
    logic [31:0] ref_h [5];

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic ref_init();
        ref_h[0] = 32'h67452301; ref_h[1] = 32'hEFCDAB89; ref_h[2] = 32'h98BADCFE;
        ref_h[3] = 32'h10325476; ref_h[4] = 32'hC3D2E1F0;
    endtask

    task automatic ref_compress(input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = m[32 * t +: 32];
        for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        a = ref_h[0]; b = ref_h[1]; c = ref_h[2]; d = ref_h[3]; e = ref_h[4];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = rl(a, 5) + f + e + k + w[t];
            e = d; d = c; c = rl(b, 30); b = a; a = tmp;
        end
        ref_h[0] += a; ref_h[1] += b; ref_h[2] += c; ref_h[3] += d; ref_h[4] += e;
    endtask

    function automatic logic [159:0] ref_digest();
        return {ref_h[4], ref_h[3], ref_h[2], ref_h[1], ref_h[0]};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[32 * i +: 32] = $urandom();
        return m;
    endfunction

    // Drive one sampling edge with the given controls, then scramble the message.
    task automatic pulse(input logic s, input logic i, input logic [511:0] m);
        start = s; init = i; message = m;
        @(posedge clk); #1;
        start = 1'b0; init = 1'b0; message = rand_block();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_idle(input string tag, input logic [159:0] exp_dig);
        check({tag, "_busy"},  160'(busy),     160'(0));
        check({tag, "_done"},  160'(done),     160'(0));
        check({tag, "_panic"}, 160'(panic),    160'(0));
        check({tag, "_idx"},   160'(loop_idx), 160'(0));
        check({tag, "_dig"},   digest,         exp_dig);
    endtask

    logic [511:0] msg_abc, msg_emp, msg_b1, msg_b2;
    int n;

    initial begin
        msg_abc = '0; msg_abc[31:0] = 32'h61626380; msg_abc[511:480] = 32'h00000018;
        msg_emp = '0; msg_emp[31:0] = 32'h80000000;
        msg_b1  = '0;
        for (int i = 0; i < 14; i++) msg_b1[32 * i +: 32] = B1_W[i];
        msg_b1[32 * 14 +: 32] = 32'h80000000;
        msg_b2  = '0; msg_b2[511:480] = 32'h000001c0;

        reset = 1'b1; start = 1'b0; init = 1'b0; message = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", IV_DIG);
        reset = 1'b0;

        // "abc": done appears 81 edges after the accepting edge (82 clocks counting it).
        pulse(1'b0, 1'b1, '0);
        pulse(1'b1, 1'b0, msg_abc);
        check("abc_busy", 160'(busy), 160'(1));
        wait_done(n);
        check("abc_lat", 160'(n), 160'(81));
        check("abc_dig", digest, ABC_DIG);
        ref_init(); ref_compress(msg_abc);
        check("abc_model", digest, ref_digest());
        $display("txn abc        digest=%h cycles=%0d", digest, n);

        // Empty message with a cycle-by-cycle loop_idx walk.
        pulse(1'b0, 1'b1, '0);
        pulse(1'b1, 1'b0, msg_emp);
        for (int k = 0; k < 80; k++) begin
            check($sformatf("emp_idx%0d", k), 160'(loop_idx), 160'(k));
            if (k % 10 == 0) check($sformatf("emp_hold%0d", k), digest, IV_DIG);
            @(posedge clk); #1;
        end
        check("emp_final_idx",  160'(loop_idx), 160'(80));
        check("emp_final_busy", 160'(busy),     160'(1));
        check("emp_final_done", 160'(done),     160'(0));
        @(posedge clk); #1;
        check("emp_done",     160'(done),     160'(1));
        check("emp_done_idx", 160'(loop_idx), 160'(80));
        check("emp_dig",      digest,         EMP_DIG);
        $display("txn empty      digest=%h", digest);

        // Two-block message chained through DONE.
        pulse(1'b0, 1'b1, '0);
        ref_init();
        pulse(1'b1, 1'b0, msg_b1);
        wait_done(n);
        ref_compress(msg_b1);
        check("two_b1_dig", digest, ref_digest());
        pulse(1'b1, 1'b0, msg_b2);
        wait_done(n);
        check("two_b2_lat", 160'(n), 160'(81));
        check("two_dig", digest, TWO_DIG);
        $display("txn two-block  digest=%h", digest);

        // Start during round 40 raises panic without disturbing the computation.
        pulse(1'b0, 1'b1, '0);
        pulse(1'b1, 1'b0, msg_abc);
        repeat (40) begin @(posedge clk); #1; end
        check("pan_idx40", 160'(loop_idx), 160'(40));
        pulse(1'b1, 1'b0, rand_block());
        check("pan_set", 160'(panic),    160'(1));
        check("pan_idx", 160'(loop_idx), 160'(41));
        wait_done(n);
        check("pan_lat",    160'(n),     160'(40));
        check("pan_dig",    digest,      ABC_DIG);
        check("pan_sticky", 160'(panic), 160'(1));
        pulse(1'b0, 1'b1, '0);
        check_idle("pan_init", IV_DIG);
        $display("txn panic      digest=%h", digest);

        // Init during round 30 aborts, then a fresh start still works.
        pulse(1'b1, 1'b0, msg_abc);
        repeat (30) begin @(posedge clk); #1; end
        pulse(1'b0, 1'b1, '0);
        check_idle("abort", IV_DIG);
        repeat (3) begin @(posedge clk); #1; end
        check("abort_stay", 160'(busy), 160'(0));
        pulse(1'b1, 1'b0, msg_abc);
        wait_done(n);
        check("abort_dig", digest, ABC_DIG);
        // init+start together from DONE restarts from IV, not from the current H.
        pulse(1'b1, 1'b1, msg_abc);
        check("both_busy", 160'(busy), 160'(1));
        check("both_dig0", digest,     IV_DIG);
        wait_done(n);
        check("both_lat", 160'(n), 160'(81));
        check("both_dig", digest,  ABC_DIG);
        $display("txn init+start digest=%h", digest);

        // Reset during round 50.
        pulse(1'b1, 1'b0, msg_emp);
        repeat (50) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("rst_mid", IV_DIG);
        pulse(1'b1, 1'b0, msg_emp);
        wait_done(n);
        check("rst_dig", digest, EMP_DIG);
        $display("txn reset-mid  digest=%h", digest);

        // Random multi-block messages against the model.
        for (int r = 0; r < 5; r++) begin
            int nb;
            logic [511:0] m;
            nb = 1 + int'($urandom_range(0, 2));
            pulse(1'b0, 1'b1, '0);
            ref_init();
            for (int b = 0; b < nb; b++) begin
                m = rand_block();
                pulse(1'b1, 1'b0, m);
                wait_done(n);
                ref_compress(m);
                check($sformatf("rnd%0d_blk%0d", r, b), digest, ref_digest());
                $display("txn random %0d.%0d digest=%h", r, b, digest);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
